// File: rtl/sram_like_slave_if.sv
// sram_like_slave_if: sram-like request/response bus between a CPU port and its memory
interface sram_like_slave_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
   modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_slave.sv
// sram_like_slave: in-order, fixed-latency memory responder for the sram-like bus
module sram_like_slave #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input logic              clk,
   input logic              reset,
   sram_like_slave_if.slave s
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [3:0] CTR_INIT = 4'(LATENCY - 1);

   logic [31:0]       mem [2**ADDR_W];
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [3:0]        ctr_q [QDEPTH];
   logic [3:0]        ctr_d [QDEPTH];
   logic [QDEPTH-1:0] wr_q, wr_d;
   logic [31:0]       snap_q [QDEPTH];
   logic [31:0]       snap_d [QDEPTH];
   logic [ADDR_W-1:0] idx;
   logic              accept, pop, unused;

   // Queue bookkeeping: snapshot is taken before this request's own write lands
   always_comb begin
      idx       = s.addr[ADDR_W+1:2];
      unused    = ^{s.size, s.addr[1:0], s.addr[31:ADDR_W+2]};
      s.addr_ok = (count_q != CW'(QDEPTH)) && !reset;
      accept    = s.req && s.addr_ok;
      pop       = (count_q != '0) && (ctr_q[head_q] == '0) && !reset;
      s.data_ok = pop;
      s.rdata   = (pop && !wr_q[head_q]) ? snap_q[head_q] : 32'h0;
      for (int i = 0; i < QDEPTH; i++) ctr_d[i] = (ctr_q[i] == '0) ? '0 : ctr_q[i] - 4'd1;
      wr_d   = wr_q;
      snap_d = snap_q;
      if (accept) begin
         ctr_d[tail_q]  = CTR_INIT;
         wr_d[tail_q]   = s.wr;
         snap_d[tail_q] = mem[idx];
      end
      head_d  = pop ? head_q + PW'(1) : head_q;
      tail_d  = accept ? tail_q + PW'(1) : tail_q;
      count_d = count_q + CW'(accept) - CW'(pop);
   end

   // Queue state; reset drops in-flight requests without a response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         wr_q    <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            ctr_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         wr_q    <= wr_d;
         ctr_q   <= ctr_d;
         snap_q  <= snap_d;
      end
   end

   // Backing store commits strobed bytes at accept; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (accept && s.wr && s.wstrb[i]) mem[idx][8*i +: 8] <= s.wdata[8*i +: 8];
   end
endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: three latency configs against a queue-of-due-times reference model
module tb_sram_like_slave;
   localparam int NI = 3;
   localparam int QD = 4;

   typedef struct {
      int          due;
      logic        wr;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic        req;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
   } vec_t;

   logic        clk = 0;
   logic        rst = 1;
   logic        req_v [NI];
   logic        wr_v [NI];
   logic [1:0]  size_v [NI];
   logic [3:0]  strb_v [NI];
   logic [31:0] addr_v [NI];
   logic [31:0] wdata_v [NI];
   logic        aok_o [NI];
   logic        dok_o [NI];
   logic [31:0] rd_o [NI];

   resp_t       rq [NI][$];
   logic [31:0] mm [NI][1024];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      sram_like_slave_if bus ();
      sram_like_slave #(.LATENCY(g == 0 ? 2 : g == 1 ? 8 : 1), .QDEPTH(QD)) dut (
         .clk(clk), .reset(rst), .s(bus));
      assign bus.req   = req_v[g];
      assign bus.wr    = wr_v[g];
      assign bus.size  = size_v[g];
      assign bus.wstrb = strb_v[g];
      assign bus.addr  = addr_v[g];
      assign bus.wdata = wdata_v[g];
      assign aok_o[g]  = bus.addr_ok;
      assign dok_o[g]  = bus.data_ok;
      assign rd_o[g]   = bus.rdata;
   end

   function automatic int lat_of(input int i);
      return i == 0 ? 2 : i == 1 ? 8 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One cycle: compare every instance against the model, then advance the model
   task automatic step();
      #1;
      for (int i = 0; i < NI; i++) begin
         logic        eaok, edok;
         logic [31:0] erd;
         int          w;
         resp_t       nr;
         eaok = !rst && rq[i].size() < QD;
         edok = !rst && rq[i].size() > 0 && rq[i][0].due == cyc;
         erd  = (edok && !rq[i][0].wr) ? rq[i][0].data : 32'h0;
         chk($sformatf("i%0d addr_ok", i), 32'(aok_o[i]), 32'(eaok));
         chk($sformatf("i%0d data_ok", i), 32'(dok_o[i]), 32'(edok));
         chk($sformatf("i%0d rdata", i), rd_o[i], erd);
         if (rst) rq[i].delete();
         else begin
            if (edok) void'(rq[i].pop_front());
            if (req_v[i] && eaok) begin
               w       = int'(addr_v[i][11:2]);
               nr.due  = cyc + lat_of(i);
               nr.wr   = wr_v[i];
               nr.data = mm[i][w];
               rq[i].push_back(nr);
               if (wr_v[i])
                  for (int b = 0; b < 4; b++)
                     if (strb_v[i][b]) mm[i][w][8*b +: 8] = wdata_v[i][8*b +: 8];
            end
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < NI; i++) req_v[i] = 0;
      for (int c = 0; c < n; c++) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        tv [15];
      int          p [NI];
      int          n, d;
      logic [23:0] acc_m, dok_m;
      logic [31:0] got;
      tv[0]  = '{1, 1, 4'hF, 32'h10,       32'hDEADBEEF, 1, 0, 32'h0};
      tv[1]  = '{1, 0, 4'h0, 32'h10,       32'h0,        1, 0, 32'h0};
      tv[2]  = '{1, 1, 4'hF, 32'h20,       32'h11223344, 1, 1, 32'h0};
      tv[3]  = '{1, 1, 4'h5, 32'h20,       32'hAABBCCDD, 1, 1, 32'hDEADBEEF};
      tv[4]  = '{1, 0, 4'h0, 32'h20,       32'h0,        1, 1, 32'h0};
      tv[5]  = '{1, 1, 4'hF, 32'h30,       32'h55555555, 1, 1, 32'h0};
      tv[6]  = '{1, 0, 4'h0, 32'h30,       32'h0,        1, 1, 32'h11BB33DD};
      tv[7]  = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h0};
      tv[8]  = '{1, 0, 4'h0, 32'h30,       32'h0,        1, 1, 32'h55555555};
      tv[9]  = '{1, 1, 4'hF, 32'h30,       32'h66666666, 1, 0, 32'h0};
      tv[10] = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h55555555};
      tv[11] = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h0};
      tv[12] = '{1, 0, 4'h0, 32'hFFFFF033, 32'h0,        1, 0, 32'h0};
      tv[13] = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h0};
      tv[14] = '{0, 0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h66666666};
      for (int i = 0; i < NI; i++) begin
         req_v[i] = 0; wr_v[i] = 0; size_v[i] = 2; strb_v[i] = 0; addr_v[i] = 0; wdata_v[i] = 0;
         p[i] = 0;
      end
      @(negedge clk);
      step();
      step();
      rst = 0;
      // preload words 0..31 with k*3 on every instance
      for (int c = 0; c < 200 && (p[0] < 32 || p[1] < 32 || p[2] < 32); c++) begin
         logic [NI-1:0] go;
         for (int i = 0; i < NI; i++) begin
            req_v[i] = p[i] < 32; wr_v[i] = 1; strb_v[i] = 4'hF;
            addr_v[i] = 32'(p[i]) << 2; wdata_v[i] = 32'(p[i] * 3);
            go[i] = req_v[i] && aok_o[i];
         end
         step();
         for (int i = 0; i < NI; i++) if (go[i]) p[i]++;
      end
      for (int i = 0; i < NI; i++) chk($sformatf("preload i%0d", i), 32'(p[i]), 32'd32);
      idle(12);
      // directed vectors on the LATENCY=2 instance
      for (int r = 0; r < 15; r++) begin
         req_v[0] = tv[r].req; wr_v[0] = tv[r].wr; strb_v[0] = tv[r].strb;
         addr_v[0] = tv[r].addr; wdata_v[0] = tv[r].wdata;
         #1;
         chk($sformatf("vec%0d addr_ok", r), 32'(aok_o[0]), 32'(tv[r].aok));
         chk($sformatf("vec%0d data_ok", r), 32'(dok_o[0]), 32'(tv[r].dok));
         chk($sformatf("vec%0d rdata", r), rd_o[0], tv[r].rd);
         step();
      end
      idle(4);
      // full queue with LATENCY=8: req held until 8 accepts
      n = 0;
      for (int c = 0; c < 24; c++) begin
         req_v[1] = n < 8; wr_v[1] = 0; addr_v[1] = 32'(n) << 2;
         acc_m[c] = req_v[1] && aok_o[1];
         dok_m[c] = dok_o[1];
         if (acc_m[c]) n++;
         step();
      end
      chk("full accept mask", 32'(acc_m), 32'h001E0F);
      chk("full data_ok mask", 32'(dok_m), 32'h1E0F00);
      idle(12);
      // LATENCY=1 streaming reads of words 0..15
      for (int c = 0; c < 18; c++) begin
         chk($sformatf("stream data_ok %0d", c), 32'(dok_o[2]), 32'(c >= 1 && c <= 16));
         chk($sformatf("stream rdata %0d", c), rd_o[2], (c >= 1 && c <= 16) ? 32'((c - 1) * 3) : 32'h0);
         req_v[2] = c < 16; wr_v[2] = 0; addr_v[2] = 32'(c) << 2;
         step();
      end
      idle(4);
      // reset with three reads in flight on the LATENCY=8 instance
      for (int c = 0; c < 3; c++) begin
         req_v[1] = 1; wr_v[1] = 0; addr_v[1] = 32'(c + 1) << 2;
         step();
      end
      req_v[1] = 0;
      rst = 1;
      #1;
      chk("reset addr_ok", 32'(aok_o[1]), 32'h0);
      chk("reset data_ok", 32'(dok_o[1]), 32'h0);
      chk("reset rdata", rd_o[1], 32'h0);
      step();
      rst = 0;
      for (int c = 0; c < 12; c++) begin
         chk("stale data_ok", 32'(dok_o[1]), 32'h0);
         step();
      end
      req_v[1] = 1; wr_v[1] = 0; addr_v[1] = 32'h14;
      step();
      req_v[1] = 0;
      d = -1;
      got = 0;
      for (int c = 1; c <= 20; c++) begin
         if (d < 0 && dok_o[1]) begin
            d = c;
            got = rd_o[1];
         end
         step();
      end
      chk("post-reset latency", 32'(d), 32'd8);
      chk("post-reset rdata", got, 32'd15);
      // randomized traffic with aliased upper/low address bits
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) begin
            req_v[i] = $urandom_range(0, 9) < 7;
            wr_v[i] = 1'($urandom);
            size_v[i] = 2'($urandom);
            strb_v[i] = 4'($urandom);
            addr_v[i] = ($urandom & 32'hFFFF_F083) | (32'($urandom_range(0, 31)) << 2);
            wdata_v[i] = $urandom;
         end
         step();
      end
      idle(12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
